// File: rtl/pll_reset_supervisor.sv
// PLL supervisor: pulses the PLL reset, waits for lock with timeout and bounded retries,
// and holds the system reset until the synchronised lock has been stable long enough.
module pll_reset_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pll_lock,
   output logic       o_pll_rst,
   output logic       o_rst,
   output logic       o_locked,
   output logic       o_fail,
   output logic [3:0] o_retries
);

   localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [3:0]    TRY_LIMIT   = 4'(MAX_RETRIES);

   localparam logic [2:0] ST_PLL_RST   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_FAIL      = 3'd4;

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [CW-1:0] cnt;
   logic [3:0]    try_cnt;
   logic [3:0]    try_next;
   logic          timeout;
   logic          sync_ff;
   logic          lock_s;

   // Lock is checked before the timeout so a lock arriving on the last cycle wins.
   always_comb begin
      next_state = state;
      timeout    = 1'b0;
      try_next   = try_cnt;
      case (state)
         ST_PLL_RST: begin
            if (cnt == RST_LAST) next_state = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               next_state = ST_STABLE;
            end else if (cnt == LOCK_LAST) begin
               timeout    = 1'b1;
               try_next   = try_cnt + 4'd1;
               next_state = (try_next == TRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
            end
         end
         ST_STABLE: begin
            if (!lock_s) next_state = ST_WAIT_LOCK;
            else if (cnt == STABLE_LAST) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (!lock_s) next_state = ST_PLL_RST;
         end
         ST_FAIL: begin
            next_state = ST_FAIL;
         end
         default: begin
            next_state = ST_PLL_RST;
         end
      endcase
      if (next_state == ST_RUN) try_next = 4'd0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_ff   <= 1'b0;
         lock_s    <= 1'b0;
         state     <= ST_PLL_RST;
         cnt       <= '0;
         try_cnt   <= 4'd0;
         o_pll_rst <= 1'b1;
         o_rst     <= 1'b1;
         o_locked  <= 1'b0;
         o_fail    <= 1'b0;
         o_retries <= 4'd0;
      end else begin
         sync_ff <= i_pll_lock;
         lock_s  <= sync_ff;
         state   <= next_state;
         try_cnt <= try_next;
         // The counter only runs in the timed states; RUN and FAIL hold it.
         if (next_state != state) begin
            cnt <= '0;
         end else if (state == ST_PLL_RST || state == ST_WAIT_LOCK || state == ST_STABLE) begin
            cnt <= cnt + CW'(1);
         end
         if (timeout && o_retries != 4'hF) o_retries <= o_retries + 4'd1;
         o_pll_rst <= (next_state == ST_PLL_RST) || (next_state == ST_FAIL);
         o_rst     <= (next_state != ST_RUN);
         o_locked  <= (next_state == ST_RUN);
         o_fail    <= (next_state == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor: a countdown-based behavioural model checked every
// cycle, plus hand-computed latency, pulse-width and retry expectations.
module tb_pll_reset_supervisor;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;

   localparam int P_PRST   = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAIL   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       locked;
   logic       fail_o;
   logic [3:0] retries;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: phase plus cycles remaining in it, and a two-entry lock history.
   int   m_phase = P_PRST;
   int   m_left  = RST_CYCLES;
   int   m_tries = 0;
   int   m_retries = 0;
   bit   m_hist0 = 1'b0;
   bit   m_hist1 = 1'b0;
   bit   m_valid = 1'b0;

   pll_reset_supervisor #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_pll_lock(pll_lock),
      .o_pll_rst (pll_rst),
      .o_rst     (sys_rst),
      .o_locked  (locked),
      .o_fail    (fail_o),
      .o_retries (retries)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit seen;
      seen = m_hist1;
      if (rst) begin
         m_phase   = P_PRST;
         m_left    = RST_CYCLES;
         m_tries   = 0;
         m_retries = 0;
         m_hist0   = 1'b0;
         m_hist1   = 1'b0;
         m_valid   = 1'b1;
      end else begin
         case (m_phase)
            P_PRST: begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_phase = P_WAIT;
                  m_left  = LOCK_TIMEOUT;
               end
            end
            P_WAIT: begin
               if (seen) begin
                  m_phase = P_STABLE;
                  m_left  = STABLE_CYCLES;
               end else begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                     m_tries   = m_tries + 1;
                     m_phase   = (m_tries == MAX_RETRIES) ? P_FAIL : P_PRST;
                     m_left    = RST_CYCLES;
                  end
               end
            end
            P_STABLE: begin
               if (!seen) begin
                  m_phase = P_WAIT;
                  m_left  = LOCK_TIMEOUT;
               end else begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_phase = P_RUN;
                     m_tries = 0;
                  end
               end
            end
            P_RUN: begin
               if (!seen) begin
                  m_phase = P_PRST;
                  m_left  = RST_CYCLES;
               end
            end
            default: m_phase = P_FAIL;
         endcase
         m_hist1 = m_hist0;
         m_hist0 = pll_lock;
      end
   endtask

   always @(posedge clk) model_step();

   function automatic logic [7:0] model_out();
      logic [3:0] r;
      r = 4'(m_retries);
      return {(m_phase == P_PRST || m_phase == P_FAIL), (m_phase != P_RUN),
              (m_phase == P_RUN), (m_phase == P_FAIL), r};
   endfunction

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         n_vec++;
         if ({pll_rst, sys_rst, locked, fail_o, retries} !== model_out()) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: got %b expected %b", $time,
                     {pll_rst, sys_rst, locked, fail_o, retries}, model_out());
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [3:0] sel(input int which);
      case (which)
         0:       return {3'b000, pll_rst};
         1:       return {3'b000, sys_rst};
         2:       return {3'b000, locked};
         3:       return {3'b000, fail_o};
         default: return retries;
      endcase
   endfunction

   task automatic wait_out(input int which, input logic [3:0] val, input int budget, input string name);
      int k;
      k = 0;
      while (sel(which) !== val && k < budget) begin
         k++;
         @(negedge clk);
      end
      n_vec++;
      if (sel(which) !== val) begin
         n_err++;
         $display("FAIL %s: timed out after %0d cycles, got %0d expected %0d", name, k, sel(which), val);
      end
   endtask

   task automatic pulse_len(output int n);
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic low_len(output int n);
      n = 0;
      while (pll_rst === 1'b0 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Edges from the first edge that samples the new pin level until o_rst falls.
   task automatic rel_edges(output int e);
      e = 0;
      do begin
         @(negedge clk);
         e++;
      end while (sys_rst === 1'b1 && e < 200);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int e;

      // 1: normal bring-up
      rst = 1'b1;
      pll_lock = 1'b0;
      cyc(2);
      check("reset_outputs", {pll_rst, sys_rst, locked, fail_o, retries}, 8'hC0);
      rst = 1'b0;
      pulse_len(n);
      check("pll_rst_width", 8'(n), 8'd4);
      cyc(3);
      pll_lock = 1'b1;
      rel_edges(e);
      check("release_latency", 8'(e - 1), 8'd10);
      check("run_locked_retries", {locked, retries}, {1'b1, 4'd0});

      // 2: lock drop while stable restarts the stable window
      pll_lock = 1'b0;
      do_reset();
      pulse_len(n);
      check("pll_rst_width_2", 8'(n), 8'd4);
      pll_lock = 1'b1;
      cyc(6);
      pll_lock = 1'b0;
      cyc(2);
      check("stable_drop_held", {sys_rst, locked}, 2'b10);
      pll_lock = 1'b1;
      rel_edges(e);
      check("restart_latency", 8'(e - 1), 8'd10);

      // 4: lock loss in RUN
      pll_lock = 1'b0;
      e = 0;
      do begin
         @(negedge clk);
         e++;
      end while (sys_rst === 1'b0 && e < 50);
      check("loss_latency", 8'(e), 8'd3);
      check("loss_outputs", {pll_rst, locked}, 2'b10);
      pll_lock = 1'b1;
      wait_out(2, 4'd1, 200, "relock");
      check("relock_retries", 8'(retries), 8'd0);

      // 3: lock never rises
      pll_lock = 1'b0;
      do_reset();
      pulse_len(n);
      check("pll_rst_width_3", 8'(n), 8'd4);
      low_len(n);
      check("wait_lock_len", 8'(n), 8'd20);
      check("retries_first_timeout", 8'(retries), 8'd1);
      pulse_len(n);
      check("retry_pulse_width", 8'(n), 8'd4);
      wait_out(3, 4'd1, 100, "reach_fail");
      check("fail_outputs", {pll_rst, sys_rst, locked, fail_o, retries}, 8'hD2);
      cyc(10);
      check("fail_hold", {pll_rst, sys_rst, locked, fail_o, retries}, 8'hD2);

      // 6: reset from FAIL and from WAIT_LOCK
      do_reset();
      check("rst_in_fail", {pll_rst, sys_rst, locked, fail_o, retries}, 8'hC0);
      pulse_len(n);
      check("pll_rst_width_6a", 8'(n), 8'd4);
      cyc(5);
      do_reset();
      check("rst_in_wait", {pll_rst, sys_rst, locked, fail_o, retries}, 8'hC0);
      pulse_len(n);
      check("pll_rst_width_6b", 8'(n), 8'd4);

      // 5: retries counted across RUN, try count cleared by RUN
      wait_out(4, 4'd1, 60, "one_timeout");
      pll_lock = 1'b1;
      wait_out(2, 4'd1, 200, "lock_after_timeout");
      check("retries_kept_in_run", 8'(retries), 8'd1);
      pll_lock = 1'b0;
      wait_out(4, 4'd2, 200, "second_timeout");
      check("retry_not_fail", {pll_rst, fail_o}, 2'b10);
      cyc(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
